// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-RAM boot loader.
package loader_pkg;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned HDR_BYTES         = 2;
  localparam int unsigned WORD_BYTES        = WORD_W / BYTE_W;
  localparam int unsigned LEN_W             = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR_HI = 3'd1,
    ST_HDR_LO = 3'd2,
    ST_BYTE   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_CSUM   = 3'd5,
    ST_RUN    = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  // Stream offset of the checksum byte for a program of n_words words.
  function automatic int unsigned csum_byte_pos(input int unsigned n_words);
    return HDR_BYTES + WORD_BYTES * n_words;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs MSB-first bytes into a 32-bit word and keeps the running XOR of all packed bytes.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xor_acc,
  output logic              last_byte_c
);

  logic [1:0] byte_cnt;

  // Shift register, byte counter and XOR accumulator; clear leaves the word untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      word     <= '0;
      byte_cnt <= '0;
      xor_acc  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      xor_acc  <= '0;
    end else if (shift_en) begin
      word     <= {word[WORD_W-BYTE_W-1:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
      xor_acc  <= xor_acc ^ byte_in;
    end
  end

  // The byte currently being offered completes the word.
  assign last_byte_c = (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_ram_loader.sv
// Loads a length-prefixed, XOR-checksummed program into instruction RAM, then hands the RAM to the CPU.
module instr_ram_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned MEM_WORDS  = MEM_WORDS_DEFAULT,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic              cpu_run,
  output logic              load_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t              state_q;
  state_t              state_nx;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]    words_q;
  logic [BYTE_W-1:0]   hdr_hi_q;
  logic [LEN_W-1:0]    n_words_q;
  logic                load_error_q;

  logic                accept_c;
  logic [LEN_W-1:0]    hdr_n_c;
  logic                hdr_ok_c;
  logic                last_word_c;
  logic                pk_clear_c;
  logic                pk_shift_c;
  logic [BYTE_W-1:0]   xor_acc;
  logic                last_byte_c;

  assign accept_c    = rx_valid && rx_ready;
  assign hdr_n_c     = {hdr_hi_q, rx_data};
  assign hdr_ok_c    = (hdr_n_c != '0) && (32'(hdr_n_c) <= MEM_WORDS);
  assign last_word_c = (32'(words_q) + 32'd1) == 32'(n_words_q);

  // A restart wins over a byte offered in the same cycle, so that byte never reaches the packer.
  assign pk_clear_c = load_start || (state_q == ST_HDR_HI);
  assign pk_shift_c = accept_c && (state_q == ST_BYTE) && !load_start;

  byte_packer u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear       (pk_clear_c),
    .shift_en    (pk_shift_c),
    .byte_in     (rx_data),
    .word        (wr_data),
    .xor_acc     (xor_acc),
    .last_byte_c (last_byte_c)
  );

  // State register; reset lands in the header phase when auto-start is enabled.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= AUTO_START ? ST_HDR_HI : ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state logic; load_start overrides every other transition.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE:   state_nx = ST_IDLE;
      ST_HDR_HI: if (accept_c) state_nx = ST_HDR_LO;
      ST_HDR_LO: if (accept_c) state_nx = hdr_ok_c ? ST_BYTE : ST_ERROR;
      ST_BYTE:   if (accept_c && last_byte_c) state_nx = ST_WRITE;
      ST_WRITE:  state_nx = last_word_c ? ST_CSUM : ST_BYTE;
      ST_CSUM:   if (accept_c) state_nx = (rx_data == xor_acc) ? ST_RUN : ST_ERROR;
      ST_RUN:    state_nx = ST_RUN;
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_IDLE;
    endcase
    if (load_start) begin
      state_nx = ST_HDR_HI;
    end
  end

  // Outputs decoded from the registered state; the RAM address follows the CPU only while it runs.
  always_comb begin
    rx_ready = 1'b0;
    wr_en    = 1'b0;
    cpu_run  = 1'b0;
    ram_addr = wr_ptr_q;
    unique case (state_q)
      ST_HDR_HI, ST_HDR_LO, ST_BYTE, ST_CSUM: rx_ready = 1'b1;
      ST_WRITE: wr_en = 1'b1;
      ST_RUN: begin
        cpu_run  = 1'b1;
        ram_addr = cpu_pc;
      end
      default: ;
    endcase
  end

  // Header capture, write pointer, word count and sticky error flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      words_q      <= '0;
      hdr_hi_q     <= '0;
      n_words_q    <= '0;
      load_error_q <= 1'b0;
    end else if (load_start) begin
      wr_ptr_q     <= '0;
      words_q      <= '0;
      load_error_q <= 1'b0;
    end else begin
      if (accept_c && (state_q == ST_HDR_HI)) begin
        hdr_hi_q <= rx_data;
      end
      if (accept_c && (state_q == ST_HDR_LO)) begin
        n_words_q <= hdr_n_c;
      end
      if (state_q == ST_WRITE) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        words_q  <= words_q + CNT_W'(1);
      end
      load_error_q <= (state_nx == ST_ERROR);
    end
  end

  assign words_loaded = words_q;
  assign load_error   = load_error_q;

endmodule
